// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder.
// Word type, channel state encoding and default latencies.
package lc3_mem_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ch_state_e;

    localparam int LAT_W = 4;

    localparam int DEF_INSTR_LAT = 1;
    localparam int DEF_DATA_LAT  = 2;

endpackage

// File: rtl/lc3_mem_channel.sv
// One request channel: captures a request payload, counts down the
// programmed latency and pulses fire in the cycle the access completes.
module lc3_mem_channel
    import lc3_mem_pkg::*;
#(
    parameter int LAT = 1,
    parameter int W   = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req,
    input  logic [W-1:0] req_info,
    output logic         fire,
    output logic [W-1:0] info
);

    ch_state_e          state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       info_q, info_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        info_d  = info_q;
        fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = LAT_W'(LAT - 1);
                    info_d  = req_info;
                end
            end
            WAIT: begin
                // Requests arriving while busy are dropped, not queued.
                if (cnt_q == '0) begin
                    fire    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            info_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            info_q  <= info_d;
        end
    end

    assign info = info_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC3 fetch and data ports, backed by a
// word array with independent programmable latency per channel.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter int    INSTR_LAT = DEF_INSTR_LAT,
  parameter int    DATA_LAT  = DEF_DATA_LAT,
  parameter string INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        Data_en,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data
);

  localparam int DW = ADDR_W + 17;

  word_t mem_q [2**ADDR_W];

  logic              i_fire;
  logic [ADDR_W-1:0] i_idx;
  logic              d_fire;
  logic [DW-1:0]     d_info;
  logic              d_rd;
  word_t             d_din;
  logic [ADDR_W-1:0] d_idx;
  logic              d_we;

  logic unused_addr_hi;
  assign unused_addr_hi =
    ^{pc[15:ADDR_W], Data_addr[15:ADDR_W]};

  lc3_mem_channel #(
    .LAT (INSTR_LAT),
    .W   (ADDR_W)
  ) u_instr (
    .clock    (clock),
    .reset    (reset),
    .req      (instrmem_rd),
    .req_info (pc[ADDR_W-1:0]),
    .fire     (i_fire),
    .info     (i_idx)
  );

  lc3_mem_channel #(
    .LAT (DATA_LAT),
    .W   (DW)
  ) u_data (
    .clock    (clock),
    .reset    (reset),
    .req      (Data_en),
    .req_info ({Data_rd, Data_din,
                Data_addr[ADDR_W-1:0]}),
    .fire     (d_fire),
    .info     (d_info)
  );

  assign d_rd  = d_info[DW-1];
  assign d_din = d_info[ADDR_W +: 16];
  assign d_idx = d_info[ADDR_W-1:0];
  assign d_we  = d_fire & ~d_rd;

  word_t i_dout_q, i_dout_d;
  word_t d_dout_q, d_dout_d;
  logic  i_cmp_q, i_cmp_d;
  logic  d_cmp_q, d_cmp_d;

  always_comb begin
    i_dout_d = i_fire ? mem_q[i_idx] : i_dout_q;
    d_dout_d = (d_fire && d_rd) ? mem_q[d_idx]
                                : d_dout_q;
    i_cmp_d  = i_fire;
    d_cmp_d  = d_fire;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_dout_q <= '0;
      d_dout_q <= '0;
      i_cmp_q  <= 1'b0;
      d_cmp_q  <= 1'b0;
    end else begin
      i_dout_q <= i_dout_d;
      d_dout_q <= d_dout_d;
      i_cmp_q  <= i_cmp_d;
      d_cmp_q  <= d_cmp_d;
    end
  end

  always_ff @(posedge clock) begin
    if (d_we) mem_q[d_idx] <= d_din;
  end

  assign Instr_dout     = i_dout_q;
  assign Data_dout      = d_dout_q;
  assign complete_instr = i_cmp_q;
  assign complete_data  = d_cmp_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: table of data ops, hand sequences for
// timing corners, and a randomized phase against a word-array model.
module tb_lc3_mem_responder;
    import lc3_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset, rst3;
    logic [15:0] pc, Data_addr, Data_din;
    logic        instrmem_rd, Data_en, Data_rd;
    logic [15:0] Instr_dout, Data_dout, i3, d3;
    logic        ci, cd, ci3, cd3;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    lc3_mem_responder u_dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .instrmem_rd    (instrmem_rd),
        .Instr_dout     (Instr_dout),
        .complete_instr (ci),
        .Data_en        (Data_en),
        .Data_rd        (Data_rd),
        .Data_addr      (Data_addr),
        .Data_din       (Data_din),
        .Data_dout      (Data_dout),
        .complete_data  (cd)
    );

    lc3_mem_responder #(.DATA_LAT(3)) u_dut3 (
        .clock          (clock),
        .reset          (rst3),
        .pc             (pc),
        .instrmem_rd    (instrmem_rd),
        .Instr_dout     (i3),
        .complete_instr (ci3),
        .Data_en        (Data_en),
        .Data_rd        (Data_rd),
        .Data_addr      (Data_addr),
        .Data_din       (Data_din),
        .Data_dout      (d3),
        .complete_data  (cd3)
    );

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t  tbl [10];
    word_t mdl [8];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic data_op(input logic rd, input logic [15:0] addr,
                           input logic [15:0] din, output logic [15:0] dout);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        Data_en = 1'b1;
        Data_rd = rd;
        Data_addr = addr;
        Data_din = din;
        tick();
        Data_en = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (cd) seen = 1;
        end
        chk("data_lat", 16'(n), 16'd2);
        dout = Data_dout;
        tick();
        chk("data_pulse", 16'(cd), 16'd0);
    endtask

    task automatic fetch(input logic [15:0] addr, output logic [15:0] dout);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        instrmem_rd = 1'b1;
        pc = addr;
        tick();
        instrmem_rd = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (ci) seen = 1;
        end
        chk("fetch_lat", 16'(n), 16'd1);
        dout = Instr_dout;
        tick();
        chk("fetch_pulse", 16'(ci), 16'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] got;
        word_t seq [3];
        int k;
        bit bad;
        int n;

        tbl[0] = '{1'b0, 16'h0003, 16'h1261, 16'h0000};
        tbl[1] = '{1'b0, 16'h0010, 16'hBEEF, 16'h0000};
        tbl[2] = '{1'b1, 16'h0010, 16'h0000, 16'hBEEF};
        tbl[3] = '{1'b0, 16'h0020, 16'hAAAA, 16'hBEEF};
        tbl[4] = '{1'b0, 16'h0021, 16'h0101, 16'hBEEF};
        tbl[5] = '{1'b0, 16'h0022, 16'h0202, 16'hBEEF};
        tbl[6] = '{1'b0, 16'hFC05, 16'h7E57, 16'hBEEF};
        tbl[7] = '{1'b1, 16'h0005, 16'h0000, 16'h7E57};
        tbl[8] = '{1'b1, 16'h0003, 16'h0000, 16'h1261};
        tbl[9] = '{1'b1, 16'h0405, 16'h0000, 16'h7E57};

        reset = 1'b1;
        rst3 = 1'b1;
        pc = '0;
        instrmem_rd = 1'b0;
        Data_en = 1'b0;
        Data_rd = 1'b0;
        Data_addr = '0;
        Data_din = '0;
        repeat (2) tick();
        reset = 1'b0;
        rst3 = 1'b0;
        tick();
        chk("rst_idout", Instr_dout, 16'h0000);
        chk("rst_ddout", Data_dout, 16'h0000);
        chk("rst_ci", 16'(ci), 16'd0);
        chk("rst_cd", 16'(cd), 16'd0);

        for (int i = 0; i < 10; i++) begin
            data_op(tbl[i].rd, tbl[i].addr, tbl[i].din, got);
            chk($sformatf("tbl%0d", i), got, tbl[i].exp);
        end

        pc = 16'h3003;
        instrmem_rd = 1'b1;
        tick();
        instrmem_rd = 1'b0;
        chk("fetch1_early", 16'(ci), 16'd0);
        tick();
        chk("fetch1_ci", 16'(ci), 16'd1);
        chk("fetch1_data", Instr_dout, 16'h1261);
        tick();
        chk("fetch1_low", 16'(ci), 16'd0);
        chk("fetch1_hold", Instr_dout, 16'h1261);

        seq[0] = 16'hAAAA;
        seq[1] = 16'h0101;
        seq[2] = 16'h0202;
        k = 0;
        pc = 16'h0020;
        instrmem_rd = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("b2b_ci%0d", c), 16'(ci), 16'(c % 2));
            if (ci && k < 3) begin
                chk($sformatf("b2b_data%0d", k), Instr_dout, seq[k]);
                k++;
                pc = pc + 16'd1;
            end
        end
        instrmem_rd = 1'b0;
        tick();
        chk("b2b_count", 16'(k), 16'd3);
        chk("b2b_end", 16'(ci), 16'd0);

        Data_en = 1'b1;
        Data_rd = 1'b0;
        Data_addr = 16'h0020;
        Data_din = 16'h5555;
        tick();
        Data_en = 1'b0;
        instrmem_rd = 1'b1;
        pc = 16'h0020;
        tick();
        instrmem_rd = 1'b0;
        tick();
        chk("conf_ci", 16'(ci), 16'd1);
        chk("conf_cd", 16'(cd), 16'd1);
        chk("conf_old", Instr_dout, 16'hAAAA);
        repeat (3) tick();
        fetch(16'h0020, got);
        chk("conf_new", got, 16'h5555);

        repeat (4) tick();
        data_op(1'b0, 16'h0040, 16'h0F0F, got);
        repeat (4) tick();
        Data_en = 1'b1;
        Data_rd = 1'b0;
        Data_addr = 16'h0040;
        Data_din = 16'h1234;
        tick();
        Data_en = 1'b0;
        tick();
        rst3 = 1'b1;
        #1;
        chk("rst3_cd", 16'(cd3), 16'd0);
        chk("rst3_ddout", d3, 16'h0000);
        chk("rst3_idout", i3, 16'h0000);
        tick();
        rst3 = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (cd3) bad = 1;
        end
        chk("rst3_no_cd", 16'(bad), 16'd0);
        Data_en = 1'b1;
        Data_rd = 1'b1;
        Data_addr = 16'h0040;
        tick();
        Data_en = 1'b0;
        n = 0;
        while (!cd3 && n < 20) begin
            tick();
            n++;
        end
        chk("rst3_lat", 16'(n), 16'd3);
        chk("rst3_keep", d3, 16'h0F0F);

        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        begin
            word_t ei, ed, ni, nd;
            bit f, d, wr;
            int fi, di;
            word_t wd;
            logic [15:0] fa, da;
            ei = '0;
            ed = '0;
            chk("rnd_rst_i", Instr_dout, ei);
            chk("rnd_rst_d", Data_dout, ed);
            for (int j = 0; j < 8; j++) begin
                mdl[j] = 16'($urandom);
                data_op(1'b0, 16'h0100 + 16'(j), mdl[j], got);
                chk("rnd_fill", got, ed);
            end
            for (int it = 0; it < 40; it++) begin
                f = 1'($urandom_range(0, 1));
                d = 1'($urandom_range(0, 1));
                wr = 1'($urandom_range(0, 1));
                fi = int'($urandom_range(0, 7));
                di = int'($urandom_range(0, 7));
                wd = 16'($urandom);
                fa = 16'(($urandom_range(0, 63) << 10) | (32'h100 + fi));
                da = 16'(($urandom_range(0, 63) << 10) | (32'h100 + di));
                ni = mdl[fi];
                nd = mdl[di];
                instrmem_rd = f;
                pc = fa;
                Data_en = d;
                Data_rd = !wr;
                Data_addr = da;
                Data_din = wd;
                tick();
                instrmem_rd = 1'b0;
                Data_en = 1'b0;
                for (int c = 1; c <= 3; c++) begin
                    tick();
                    if (f && c == 1) ei = ni;
                    if (d && !wr && c == 2) ed = nd;
                    chk("rnd_ci", 16'(ci), 16'(f && c == 1));
                    chk("rnd_idout", Instr_dout, ei);
                    chk("rnd_cd", 16'(cd), 16'(d && c == 2));
                    chk("rnd_ddout", Data_dout, ed);
                end
                if (d && wr) mdl[di] = wd;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
